csc_seq_ctrl: RTL and testbench
===============================

Name: csc_seq_ctrl

Overview:
- Job-level sequencer for the CSC row-vector generator datapath (the block that consumes z0/z1/s/a0/a1 over a valid/ready handshake and returns four S values plus packed column indices).
- Walks a parameter RAM entry by entry and presents each entry to the datapath.
- Collects each datapath result and writes it to the CSC store write port at sequential addresses.
- Raises a one-cycle done pulse when the job completes.

Parameters:
- MAT_RANK, 256, matrix rank; sets index and length widths (IDX_W = $clog2(MAT_RANK), LEN_W = IDX_W+1).
- ADDR_W, 10, CSC store write-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  job start strobe; accepted only in IDLE
- job_len  in  LEN_W  number of entries (0..MAT_RANK); sampled on accepted start
- base_addr  in  ADDR_W  first store address; sampled on accepted start
- abort  in  1  cancels the job; returns to IDLE next cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- prm_rd_en  out  1  parameter RAM read strobe
- prm_rd_addr  out  IDX_W  parameter RAM address
- prm_rd_data  in  256  read data, valid 1 cycle after prm_rd_en; packing {a1_r,a1_i,a0_r,a0_i,s_r,s_i,z1,z0}, z0 in bits [31:0]
- z0, z1, s_val_i, s_val_r, a0_val_i, a0_val_r, a1_val_i, a1_val_r  out  32 each  registered operands to the datapath
- val_vld  out  1  operand valid to the datapath
- val_rdy  in  1  datapath ready
- S_vld_o  in  1  datapath result valid
- S_rdy_o  out  1  result ready to the datapath
- wr_en  out  1  store write strobe
- wr_addr  out  ADDR_W  store write address
- wr_rdy  in  1  store can accept a write

Behaviour:
- Reset values: busy=0, done=0, prm_rd_en=0, prm_rd_addr=0, all operand outputs=0, val_vld=0, S_rdy_o=1 (IDLE drain), wr_en=0, wr_addr=0. Internal state: FSM=IDLE, entry counter cnt=0.
- FSM states: IDLE, FETCH, WAIT, ISSUE, COLLECT, DONE.
- IDLE:
  - On start with job_len>0: latch len and base, set cnt=0, go to FETCH.
  - On start with job_len=0: go to DONE.
- FETCH: prm_rd_en=1 for one cycle, prm_rd_addr=cnt; go to WAIT.
- WAIT: register prm_rd_data fields onto the operand outputs; go to ISSUE.
- ISSUE:
  - val_vld=1 and operands held stable until val_vld & val_rdy.
  - val_vld deasserts on the cycle after the handshake; go to COLLECT.
- COLLECT:
  - S_rdy_o = wr_rdy.
  - wr_en = S_vld_o & wr_rdy (combinational); wr_addr = base + cnt, truncated to ADDR_W (wraps).
  - On the write cycle: if cnt==len-1 go to DONE, else cnt+1 and go to FETCH.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Per-entry latency with no stalls: FETCH 1 + WAIT 1 + ISSUE ≥1 + datapath 1 + COLLECT ≥1, about 5 cycles. A job of N entries finishes in ≤5N+2 cycles when there is no backpressure.
- S_rdy_o is 1 in IDLE so stale datapath results are drained without a write. S_rdy_o is 0 in FETCH, WAIT, ISSUE and DONE.
- start while busy: ignored, no effect.
- abort:
  - Takes priority over every other transition.
  - FSM goes to IDLE next cycle; val_vld and prm_rd_en drop the same edge.
  - done is not pulsed; cnt is cleared.
  - If abort and start coincide in IDLE, abort wins and start is ignored.
- No wr_en is ever asserted outside COLLECT.
- rst_n low mid-job: immediate return to reset values.

Optional Feature:
- CSC_SEQ_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [31:0]. It counts cycles in ISSUE with val_rdy=0 plus cycles in COLLECT with S_vld_o=1 and wr_rdy=0.
  - Cleared on accepted start, saturates at 32'hFFFF_FFFF, reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package csc_pkg holds:
  - the FSM state enum (3-bit encoding);
  - localparams PRM_W=256 and the field offsets Z0_OFS=0, Z1_OFS=32, SI_OFS=64, SR_OFS=96, A0I_OFS=128, A0R_OFS=160, A1I_OFS=192, A1R_OFS=224;
  - IDX_W/LEN_W helper functions.
- Sub-module: none required. The operand register bank may be split out as csc_prm_unpack (registered unpack on a load strobe).

Test Plan:
- job_len=3, base=0x010, val_rdy=1, wr_rdy=1, datapath model answers 1 cycle after accept -> prm_rd_addr sequence 0,1,2; wr_addr 0x010,0x011,0x012; exactly 3 wr_en; one done pulse; busy falls with done.
- job_len=0 start -> no prm_rd_en, no val_vld, done pulse 2 cycles after start.
- Hold val_rdy=0 for 4 cycles in ISSUE -> operands and val_vld stable all 4 cycles; with CSC_SEQ_STALL_CNT_EN, stall_cnt=4.
- wr_rdy=0 for 3 cycles while S_vld_o=1 -> S_rdy_o=0, no wr_en; then one write at the correct address when wr_rdy rises.
- abort asserted in COLLECT of entry 1 of a 4-entry job -> IDLE next cycle, no done; a stale S_vld_o is drained with S_rdy_o=1 and no wr_en; a following job restarts at prm_rd_addr 0.
- base_addr=0x3FE, ADDR_W=10, job_len=4 -> wr_addr 0x3FE,0x3FF,0x000,0x001; start pulsed mid-job is ignored.

Source files
------------

// File: rtl/csc_pkg.sv
// rtl/csc_pkg.sv - FSM encoding, parameter-word field offsets and width helpers for the CSC job sequencer
package csc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_COLLECT = 3'd4,
    ST_DONE    = 3'd5
  } csc_state_e;

  localparam int PRM_W   = 256;
  localparam int FLD_W   = 32;
  localparam int Z0_OFS  = 0;
  localparam int Z1_OFS  = 32;
  localparam int SI_OFS  = 64;
  localparam int SR_OFS  = 96;
  localparam int A0I_OFS = 128;
  localparam int A0R_OFS = 160;
  localparam int A1I_OFS = 192;
  localparam int A1R_OFS = 224;

  // Entry index width; a rank of 1 still needs one address bit.
  function automatic int csc_idx_w(input int rank);
    return (rank > 1) ? $clog2(rank) : 1;
  endfunction

  // Length must also represent a full job of MAT_RANK entries.
  function automatic int csc_len_w(input int rank);
    return csc_idx_w(rank) + 1;
  endfunction

endpackage

// File: rtl/csc_prm_unpack.sv
// rtl/csc_prm_unpack.sv - registered unpack of one parameter-RAM word into the eight datapath operands
module csc_prm_unpack
  import csc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [PRM_W-1:0] i_data,
  output logic [31:0]      o_z0,
  output logic [31:0]      o_z1,
  output logic [31:0]      o_s_i,
  output logic [31:0]      o_s_r,
  output logic [31:0]      o_a0_i,
  output logic [31:0]      o_a0_r,
  output logic [31:0]      o_a1_i,
  output logic [31:0]      o_a1_r
);

  logic [31:0] r_z0, r_z1, r_s_i, r_s_r, r_a0_i, r_a0_r, r_a1_i, r_a1_r;

  // Operands only change on a load so they stay stable while the datapath stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z0   <= '0;
      r_z1   <= '0;
      r_s_i  <= '0;
      r_s_r  <= '0;
      r_a0_i <= '0;
      r_a0_r <= '0;
      r_a1_i <= '0;
      r_a1_r <= '0;
    end else if (i_load) begin
      r_z0   <= i_data[Z0_OFS  +: FLD_W];
      r_z1   <= i_data[Z1_OFS  +: FLD_W];
      r_s_i  <= i_data[SI_OFS  +: FLD_W];
      r_s_r  <= i_data[SR_OFS  +: FLD_W];
      r_a0_i <= i_data[A0I_OFS +: FLD_W];
      r_a0_r <= i_data[A0R_OFS +: FLD_W];
      r_a1_i <= i_data[A1I_OFS +: FLD_W];
      r_a1_r <= i_data[A1R_OFS +: FLD_W];
    end
  end

  assign o_z0   = r_z0;
  assign o_z1   = r_z1;
  assign o_s_i  = r_s_i;
  assign o_s_r  = r_s_r;
  assign o_a0_i = r_a0_i;
  assign o_a0_r = r_a0_r;
  assign o_a1_i = r_a1_i;
  assign o_a1_r = r_a1_r;

endmodule

// File: rtl/csc_seq_ctrl.sv
// rtl/csc_seq_ctrl.sv - CSC job sequencer: parameter fetch, datapath issue, result store; CSC_SEQ_STALL_CNT_EN adds stall_cnt
module csc_seq_ctrl
  import csc_pkg::*;
#(
  parameter  int MAT_RANK = 256,
  parameter  int ADDR_W   = 10,
  localparam int IDX_W    = csc_idx_w(MAT_RANK),
  localparam int LEN_W    = csc_len_w(MAT_RANK)
) (
`ifdef CSC_SEQ_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              prm_rd_en,
  output logic [IDX_W-1:0]  prm_rd_addr,
  input  logic [PRM_W-1:0]  prm_rd_data,
  output logic [31:0]       z0,
  output logic [31:0]       z1,
  output logic [31:0]       s_val_i,
  output logic [31:0]       s_val_r,
  output logic [31:0]       a0_val_i,
  output logic [31:0]       a0_val_r,
  output logic [31:0]       a1_val_i,
  output logic [31:0]       a1_val_r,
  output logic              val_vld,
  input  logic              val_rdy,
  input  logic              S_vld_o,
  output logic              S_rdy_o,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_rdy
);

  csc_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_base;
  logic              r_done;
  logic              w_start_ok;
  logic              w_wr;
  logic              w_last;
  logic              w_load;

  assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
  assign w_wr       = (r_state == ST_COLLECT) && S_vld_o && wr_rdy;
  assign w_last     = (LEN_W'(r_cnt) == (r_len - LEN_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start) w_state_nxt = (job_len == '0) ? ST_DONE : ST_FETCH;
        ST_FETCH:   w_state_nxt = ST_WAIT;
        ST_WAIT:    w_state_nxt = ST_ISSUE;
        ST_ISSUE:   if (val_rdy) w_state_nxt = ST_COLLECT;
        ST_COLLECT: if (w_wr) w_state_nxt = w_last ? ST_DONE : ST_FETCH;
        ST_DONE:    w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs; IDLE keeps S_rdy_o high to drain stale results without writing.
  always_comb begin
    busy      = 1'b1;
    prm_rd_en = 1'b0;
    val_vld   = 1'b0;
    S_rdy_o   = 1'b0;
    wr_en     = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE:    begin busy = 1'b0; S_rdy_o = 1'b1; end
      ST_FETCH:   prm_rd_en = 1'b1;
      ST_WAIT:    w_load = 1'b1;
      ST_ISSUE:   val_vld = 1'b1;
      ST_COLLECT: begin S_rdy_o = wr_rdy; wr_en = w_wr; end
      default:    ;
    endcase
  end

  // Job context: entry counter, latched length and base address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_len  <= '0;
      r_base <= '0;
    end else if (abort) begin
      r_cnt  <= '0;
    end else if (w_start_ok) begin
      r_cnt  <= '0;
      r_len  <= job_len;
      r_base <= base_addr;
    end else if (w_wr && !w_last) begin
      r_cnt  <= r_cnt + IDX_W'(1);
    end
  end

  // Done pulse follows the DONE state by one cycle, so it coincides with busy falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (r_state == ST_DONE) && !abort;
  end

  assign done        = r_done;
  assign prm_rd_addr = r_cnt;
  assign wr_addr     = r_base + ADDR_W'(r_cnt);

  csc_prm_unpack u_unpack (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (prm_rd_data),
    .o_z0   (z0),
    .o_z1   (z1),
    .o_s_i  (s_val_i),
    .o_s_r  (s_val_r),
    .o_a0_i (a0_val_i),
    .o_a0_r (a0_val_r),
    .o_a1_i (a1_val_i),
    .o_a1_r (a1_val_r)
  );

`ifdef CSC_SEQ_STALL_CNT_EN
  logic [31:0] r_stall;
  logic        w_stall_evt;

  assign w_stall_evt = ((r_state == ST_ISSUE) && !val_rdy) ||
                       ((r_state == ST_COLLECT) && S_vld_o && !wr_rdy);

  // Saturating backpressure cycle counter, restarted with each accepted job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_stall <= '0;
    else if (w_start_ok)                     r_stall <= '0;
    else if (w_stall_evt && (r_stall != '1)) r_stall <= r_stall + 32'd1;
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_csc_seq_ctrl.sv
// tb/tb_csc_seq_ctrl.sv - directed self-checking bench for csc_seq_ctrl
module tb_csc_seq_ctrl;

  localparam int ADDR_W = 10;
  localparam int IDX_W  = 8;
  localparam int LEN_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, val_rdy, S_vld_o, wr_rdy;
  logic [LEN_W-1:0]  job_len;
  logic [ADDR_W-1:0] base_addr;
  logic [255:0]      prm_rd_data;
  logic              busy, done, prm_rd_en, val_vld, S_rdy_o, wr_en;
  logic [IDX_W-1:0]  prm_rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       z0, z1, s_val_i, s_val_r, a0_val_i, a0_val_r, a1_val_i, a1_val_r;
`ifdef CSC_SEQ_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  int          rd_q[$];
  int          wr_q[$];
  logic [31:0] z0_q[$];
  logic [31:0] a1_q[$];
  int          done_cnt, done_cyc, vld_cnt;
  logic        busy_at_done, busy_before_done;

  csc_seq_ctrl #(.MAT_RANK(256), .ADDR_W(ADDR_W)) dut (
`ifdef CSC_SEQ_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .job_len     (job_len),
    .base_addr   (base_addr),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .prm_rd_en   (prm_rd_en),
    .prm_rd_addr (prm_rd_addr),
    .prm_rd_data (prm_rd_data),
    .z0          (z0),
    .z1          (z1),
    .s_val_i     (s_val_i),
    .s_val_r     (s_val_r),
    .a0_val_i    (a0_val_i),
    .a0_val_r    (a0_val_r),
    .a1_val_i    (a1_val_i),
    .a1_val_r    (a1_val_r),
    .val_vld     (val_vld),
    .val_rdy     (val_rdy),
    .S_vld_o     (S_vld_o),
    .S_rdy_o     (S_rdy_o),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_rdy      (wr_rdy)
  );

  always #5 clk = ~clk;

  // Field k of parameter entry a.
  function automatic logic [31:0] pat(input int a, input int k);
    return 32'hA500_0000 | 32'(a << 8) | 32'(k);
  endfunction

  function automatic logic [255:0] prm_word(input int a);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = pat(a, k);
    return w;
  endfunction

  // One clock: RAM model answers a read one cycle later, datapath model answers one cycle after accept.
  task automatic cyc();
    logic acc, tkn, rd;
    int   ra;
    acc = val_vld & val_rdy;
    tkn = S_vld_o & S_rdy_o;
    rd  = prm_rd_en;
    ra  = int'(prm_rd_addr);
    @(posedge clk);
    #1;
    if (rd) prm_rd_data = prm_word(ra);
    if (acc) S_vld_o = 1'b1;
    else if (tkn) S_vld_o = 1'b0;
    #1;
  endtask

  task automatic run_job(input int len, input int base, input int max_cyc, input int mid_start_at);
    logic prev_busy;
    rd_q.delete(); wr_q.delete(); z0_q.delete(); a1_q.delete();
    done_cnt = 0; done_cyc = -1; vld_cnt = 0;
    busy_at_done = 1'bx; busy_before_done = 1'bx; prev_busy = 1'b0;
    job_len = LEN_W'(len); base_addr = ADDR_W'(base);
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (prm_rd_en) rd_q.push_back(int'(prm_rd_addr));
      if (wr_en) wr_q.push_back(int'(wr_addr));
      if (val_vld) vld_cnt++;
      if (val_vld && val_rdy) begin z0_q.push_back(z0); a1_q.push_back(a1_val_r); end
      if (done) begin done_cnt++; done_cyc = c; busy_at_done = busy; busy_before_done = prev_busy; end
      prev_busy = busy;
      if (c == mid_start_at) start = 1'b1;
      cyc();
      start = 1'b0;
      if (done_cyc > 0 && c >= done_cyc + 2) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc(); cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (prm_rd_en !== 1'b0) begin bad++; $display("FAIL reset_prm_rd_en got=%b exp=0", prm_rd_en); end
    total++; if (prm_rd_addr !== 8'h00) begin bad++; $display("FAIL reset_prm_rd_addr got=%h exp=00", prm_rd_addr); end
    total++; if (val_vld !== 1'b0) begin bad++; $display("FAIL reset_val_vld got=%b exp=0", val_vld); end
    total++; if (S_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_S_rdy_o got=%b exp=1", S_rdy_o); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (wr_addr !== 10'h000) begin bad++; $display("FAIL reset_wr_addr got=%h exp=000", wr_addr); end
    total++; if ({z0, s_val_r, a1_val_r} !== 96'h0) begin bad++; $display("FAIL reset_operands got=%h exp=0", {z0, s_val_r, a1_val_r}); end
`ifdef CSC_SEQ_STALL_CNT_EN
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    rst_n = 1'b1; cyc();
    // Reset asserted mid-job returns outputs to reset values immediately.
    job_len = 9'd2; base_addr = 10'h040; start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (z0 !== pat(0, 0)) begin bad++; $display("FAIL midrst_loaded_z0 got=%h exp=%h", z0, pat(0, 0)); end
    rst_n = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (val_vld !== 1'b0) begin bad++; $display("FAIL midrst_val_vld got=%b exp=0", val_vld); end
    total++; if (z0 !== 32'h0) begin bad++; $display("FAIL midrst_z0 got=%h exp=0", z0); end
    total++; if (wr_addr !== 10'h000) begin bad++; $display("FAIL midrst_wr_addr got=%h exp=000", wr_addr); end
    S_vld_o = 1'b0; cyc(); rst_n = 1'b1; cyc();
  endtask

  task automatic test_basic();
    val_rdy = 1'b1; wr_rdy = 1'b1;
    run_job(3, 'h010, 40, 0);
    total++; if (rd_q.size() != 3) begin bad++; $display("FAIL basic_rd_count got=%0d exp=3", rd_q.size()); end
    total++; if (wr_q.size() != 3) begin bad++; $display("FAIL basic_wr_count got=%0d exp=3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rd_q[i] != i) begin bad++; $display("FAIL basic_rd_addr[%0d] got=%0d exp=%0d", i, rd_q[i], i); end
      total++; if (wr_q[i] != 'h010 + i) begin bad++; $display("FAIL basic_wr_addr[%0d] got=%0h exp=%0h", i, wr_q[i], 'h010 + i); end
      total++; if (z0_q[i] !== pat(i, 0)) begin bad++; $display("FAIL basic_z0[%0d] got=%h exp=%h", i, z0_q[i], pat(i, 0)); end
      total++; if (a1_q[i] !== pat(i, 7)) begin bad++; $display("FAIL basic_a1r[%0d] got=%h exp=%h", i, a1_q[i], pat(i, 7)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_at_done); end
    total++; if (busy_before_done !== 1'b1) begin bad++; $display("FAIL basic_busy_before_done got=%b exp=1", busy_before_done); end
    total++; if (done_cyc < 1 || done_cyc > 17) begin bad++; $display("FAIL basic_latency got=%0d exp<=17", done_cyc); end
  endtask

  task automatic test_len0();
    run_job(0, 'h000, 10, 0);
    total++; if (rd_q.size() != 0) begin bad++; $display("FAIL len0_prm_rd got=%0d exp=0", rd_q.size()); end
    total++; if (vld_cnt != 0) begin bad++; $display("FAIL len0_val_vld got=%0d exp=0", vld_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL len0_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_cyc != 2) begin bad++; $display("FAIL len0_done_cycle got=%0d exp=2", done_cyc); end
  endtask

  task automatic test_issue_stall();
    val_rdy = 1'b0; wr_rdy = 1'b1;
    job_len = 9'd1; base_addr = 10'h020; start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (val_vld) break;
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (val_vld !== 1'b1) begin bad++; $display("FAIL stall_val_vld[%0d] got=%b exp=1", i, val_vld); end
      total++; if (z0 !== pat(0, 0)) begin bad++; $display("FAIL stall_z0[%0d] got=%h exp=%h", i, z0, pat(0, 0)); end
      total++; if (s_val_r !== pat(0, 3)) begin bad++; $display("FAIL stall_s_r[%0d] got=%h exp=%h", i, s_val_r, pat(0, 3)); end
      total++; if (a1_val_r !== pat(0, 7)) begin bad++; $display("FAIL stall_a1r[%0d] got=%h exp=%h", i, a1_val_r, pat(0, 7)); end
      cyc();
    end
    val_rdy = 1'b1; #1;
    total++; if (val_vld !== 1'b1) begin bad++; $display("FAIL stall_vld_at_hs got=%b exp=1", val_vld); end
    cyc();
    total++; if (val_vld !== 1'b0) begin bad++; $display("FAIL stall_vld_after_hs got=%b exp=0", val_vld); end
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL stall_wr_en got=%b exp=1", wr_en); end
    total++; if (wr_addr !== 10'h020) begin bad++; $display("FAIL stall_wr_addr got=%h exp=020", wr_addr); end
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", done); end
`ifdef CSC_SEQ_STALL_CNT_EN
    total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL stall_cnt_issue got=%0d exp=4", stall_cnt); end
`endif
    cyc();
  endtask

  task automatic test_wr_backpressure();
    val_rdy = 1'b1; wr_rdy = 1'b0;
    job_len = 9'd1; base_addr = 10'h055; start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (S_vld_o) break;
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (S_vld_o !== 1'b1) begin bad++; $display("FAIL bp_s_vld[%0d] got=%b exp=1", i, S_vld_o); end
      total++; if (S_rdy_o !== 1'b0) begin bad++; $display("FAIL bp_s_rdy[%0d] got=%b exp=0", i, S_rdy_o); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL bp_wr_en[%0d] got=%b exp=0", i, wr_en); end
      cyc();
    end
    wr_rdy = 1'b1; #1;
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL bp_wr_release got=%b exp=1", wr_en); end
    total++; if (S_rdy_o !== 1'b1) begin bad++; $display("FAIL bp_s_rdy_release got=%b exp=1", S_rdy_o); end
    total++; if (wr_addr !== 10'h055) begin bad++; $display("FAIL bp_wr_addr got=%h exp=055", wr_addr); end
    cyc();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL bp_single_write got=%b exp=0", wr_en); end
`ifdef CSC_SEQ_STALL_CNT_EN
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt_collect got=%0d exp=3", stall_cnt); end
`endif
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done); end
    cyc();
  endtask

  task automatic test_abort();
    int wr_seen;
    int done_seen;
    wr_seen = 0; done_seen = 0;
    val_rdy = 1'b1; wr_rdy = 1'b1;
    job_len = 9'd4; base_addr = 10'h100; start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wr_en) wr_seen++;
      if (val_vld && prm_rd_addr == 8'd1) begin wr_rdy = 1'b0; break; end
      cyc();
    end
    total++; if (wr_seen != 1) begin bad++; $display("FAIL abort_entry0_writes got=%0d exp=1", wr_seen); end
    cyc();
    total++; if (S_vld_o !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL abort_in_collect got=%b%b%b exp=110", S_vld_o, busy, wr_en); end
    abort = 1'b1; cyc(); abort = 1'b0;
    wr_rdy = 1'b1; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (val_vld !== 1'b0 || prm_rd_en !== 1'b0) begin bad++; $display("FAIL abort_strobes got=%b%b exp=00", val_vld, prm_rd_en); end
    total++; if (prm_rd_addr !== 8'h00) begin bad++; $display("FAIL abort_cnt_clear got=%h exp=00", prm_rd_addr); end
    total++; if (S_rdy_o !== 1'b1) begin bad++; $display("FAIL abort_drain_rdy got=%b exp=1", S_rdy_o); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL abort_drain_wr_en got=%b exp=0", wr_en); end
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      cyc();
    end
    total++; if (S_vld_o !== 1'b0) begin bad++; $display("FAIL abort_drained got=%b exp=0", S_vld_o); end
    total++; if (done_seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    abort = 1'b1; start = 1'b1; job_len = 9'd2; cyc(); abort = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_coincide got=%b exp=0", busy); end
    run_job(1, 'h200, 20, 0);
    total++; if (rd_q.size() != 1 || rd_q[0] != 0) begin bad++; $display("FAIL abort_restart_rd got=%0d entries first=%0d exp=1 entries first=0", rd_q.size(), rd_q[0]); end
    total++; if (wr_q.size() != 1 || wr_q[0] != 'h200) begin bad++; $display("FAIL abort_restart_wr got=%0h exp=200", wr_q[0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL abort_restart_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_wrap();
    int exp_a[4];
    exp_a = '{'h3FE, 'h3FF, 'h000, 'h001};
    val_rdy = 1'b1; wr_rdy = 1'b1;
    run_job(4, 'h3FE, 60, 5);
    total++; if (wr_q.size() != 4) begin bad++; $display("FAIL wrap_wr_count got=%0d exp=4", wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (wr_q[i] != exp_a[i]) begin bad++; $display("FAIL wrap_wr_addr[%0d] got=%0h exp=%0h", i, wr_q[i], exp_a[i]); end
    end
    total++; if (rd_q.size() != 4 || rd_q[3] != 3) begin bad++; $display("FAIL wrap_rd_seq got=%0d entries last=%0d exp=4 entries last=3", rd_q.size(), rd_q[3]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done_count got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; job_len = '0; base_addr = '0;
    val_rdy = 1'b1; wr_rdy = 1'b1; S_vld_o = 1'b0; prm_rd_data = '0;
    test_reset();
    test_basic();
    test_len0();
    test_issue_stall();
    test_wr_backpressure();
    test_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
